// File: rtl/grf_scoreboard.sv
// grf_scoreboard: 32x32 general register file with write-through bypass and a
// per-register in-flight write scoreboard.
//
// The writeback stream (WE_W/A3_W/RESULT_W) commits results and retires one
// outstanding write on its destination. Decode reads two registers through
// combinational, bypassed read ports. Decode also reports each issuing
// register-writing instruction (ISSUE_*), which adds one outstanding write.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   WE_W, A3_W, RESULT_W  writeback enable / destination / data
//   A1_D, A2_D          decode read addresses
//   RD1_D, RD2_D        bypassed read data (combinational)
//   ISSUE_D, ISSUE_WE_D, ISSUE_A3_D  issue strobe, issue-writes flag, destination
//   BUSY1_D, BUSY2_D    source has an outstanding write that bypass cannot cover
//   ERR                 sticky overflow/underflow flag, cleared by reset only
module grf_scoreboard #(
  parameter int MAX_INFLIGHT = 3,
  parameter int REG_COUNT    = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        WE_W,
  input  logic [4:0]  A3_W,
  input  logic [31:0] RESULT_W,
  input  logic [4:0]  A1_D,
  input  logic [4:0]  A2_D,
  output logic [31:0] RD1_D,
  output logic [31:0] RD2_D,
  input  logic        ISSUE_D,
  input  logic        ISSUE_WE_D,
  input  logic [4:0]  ISSUE_A3_D,
  output logic        BUSY1_D,
  output logic        BUSY2_D,
  output logic        ERR
);

  localparam logic [1:0] CNT_MAX = 2'(MAX_INFLIGHT);

  logic [31:0] regs_r [REG_COUNT];
  logic [1:0]  cnt_r  [REG_COUNT];
  logic        err_r;

  logic        inc_s;
  logic        dec_s;
  logic        same_s;
  logic        ovf_s;
  logic        unf_s;
  logic        retire1_s;
  logic        retire2_s;
  logic [31:0] rd1_s;
  logic [31:0] rd2_s;
  logic        busy1_s;
  logic        busy2_s;

  // Scoreboard events for this cycle: issue, retire and their error conditions.
  always_comb begin
    inc_s  = ISSUE_D & ISSUE_WE_D & (ISSUE_A3_D != 5'd0);
    dec_s  = WE_W & (A3_W != 5'd0);
    // Issue and retire on one register cancel; no count change, no error.
    same_s = inc_s & dec_s & (ISSUE_A3_D == A3_W);
    ovf_s  = 1'b0;
    unf_s  = 1'b0;
    if (!same_s) begin
      ovf_s = inc_s & (cnt_r[ISSUE_A3_D] == CNT_MAX);
      unf_s = dec_s & (cnt_r[A3_W] == 2'd0);
    end else begin
      ovf_s = 1'b0;
      unf_s = 1'b0;
    end
  end

  // Read ports: zero register, then same-cycle writeback bypass, then storage.
  // While reset is asserted the storage is treated as already cleared.
  always_comb begin
    rd1_s = 32'd0;
    if (A1_D == 5'd0) begin
      rd1_s = 32'd0;
    end else if (WE_W && (A3_W == A1_D)) begin
      rd1_s = RESULT_W;
    end else if (reset) begin
      rd1_s = 32'd0;
    end else begin
      rd1_s = regs_r[A1_D];
    end

    rd2_s = 32'd0;
    if (A2_D == 5'd0) begin
      rd2_s = 32'd0;
    end else if (WE_W && (A3_W == A2_D)) begin
      rd2_s = RESULT_W;
    end else if (reset) begin
      rd2_s = 32'd0;
    end else begin
      rd2_s = regs_r[A2_D];
    end
  end

  // Busy: outstanding writes minus the one retiring right now (bypass covers it).
  // A retire with nothing outstanding is an underflow, not a hazard.
  always_comb begin
    retire1_s = dec_s & (A3_W == A1_D);
    retire2_s = dec_s & (A3_W == A2_D);

    busy1_s = 1'b0;
    if (reset || (A1_D == 5'd0)) begin
      busy1_s = 1'b0;
    end else if (retire1_s) begin
      busy1_s = (cnt_r[A1_D] > 2'd1);
    end else begin
      busy1_s = (cnt_r[A1_D] != 2'd0);
    end

    busy2_s = 1'b0;
    if (reset || (A2_D == 5'd0)) begin
      busy2_s = 1'b0;
    end else if (retire2_s) begin
      busy2_s = (cnt_r[A2_D] > 2'd1);
    end else begin
      busy2_s = (cnt_r[A2_D] != 2'd0);
    end
  end

  // Register storage, in-flight counters and the sticky error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs_r[i] <= 32'd0;
        cnt_r[i]  <= 2'd0;
      end
      err_r <= 1'b0;
    end else begin
      // The write commits even on underflow.
      if (dec_s) begin
        regs_r[A3_W] <= RESULT_W;
      end
      if (inc_s && !same_s && !ovf_s) begin
        cnt_r[ISSUE_A3_D] <= cnt_r[ISSUE_A3_D] + 2'd1;
      end
      if (dec_s && !same_s && !unf_s) begin
        cnt_r[A3_W] <= cnt_r[A3_W] - 2'd1;
      end
      err_r <= err_r | ovf_s | unf_s;
    end
  end

  assign RD1_D   = rd1_s;
  assign RD2_D   = rd2_s;
  assign BUSY1_D = busy1_s;
  assign BUSY2_D = busy2_s;
  // ERR reads as clear for the whole reset cycle, not only after the edge.
  assign ERR     = err_r & ~reset;

endmodule

// File: tb/tb_grf_scoreboard.sv
// Self-checking bench for grf_scoreboard: a driver issues one stimulus per cycle
// and pushes the reference model's expected outputs; a monitor pops and compares.
module tb_grf_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic        WE_W;
  logic [4:0]  A3_W;
  logic [31:0] RESULT_W;
  logic [4:0]  A1_D;
  logic [4:0]  A2_D;
  logic [31:0] RD1_D;
  logic [31:0] RD2_D;
  logic        ISSUE_D;
  logic        ISSUE_WE_D;
  logic [4:0]  ISSUE_A3_D;
  logic        BUSY1_D;
  logic        BUSY2_D;
  logic        ERR;

  always #5 clk = ~clk;

  grf_scoreboard dut (
    .clk(clk), .reset(reset), .WE_W(WE_W), .A3_W(A3_W), .RESULT_W(RESULT_W),
    .A1_D(A1_D), .A2_D(A2_D), .RD1_D(RD1_D), .RD2_D(RD2_D),
    .ISSUE_D(ISSUE_D), .ISSUE_WE_D(ISSUE_WE_D), .ISSUE_A3_D(ISSUE_A3_D),
    .BUSY1_D(BUSY1_D), .BUSY2_D(BUSY2_D), .ERR(ERR)
  );

  typedef struct {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        b1;
    logic        b2;
    logic        err;
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;

  // Reference model: architectural registers, outstanding-write counts, error flag.
  int unsigned mregs[32];
  int          mcnt[32];
  bit          merr;

  function automatic logic [31:0] model_rd(input logic [4:0] a);
    if (a == 0) return 32'd0;
    if (WE_W && A3_W == a) return RESULT_W;
    if (reset) return 32'd0;
    return mregs[a];
  endfunction

  function automatic logic model_busy(input logic [4:0] a);
    int pending;
    if (reset || a == 0) return 1'b0;
    pending = mcnt[a];
    if (WE_W && A3_W == a) pending = pending - 1;
    return (pending > 0);
  endfunction

  function automatic void model_edge();
    bit inc, dec;
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        mregs[i] = 0;
        mcnt[i]  = 0;
      end
      merr = 1'b0;
      return;
    end
    inc = ISSUE_D && ISSUE_WE_D && ISSUE_A3_D != 0;
    dec = WE_W && A3_W != 0;
    if (dec) mregs[A3_W] = RESULT_W;
    if (inc && dec && ISSUE_A3_D == A3_W) return;
    if (inc) begin
      if (mcnt[ISSUE_A3_D] == 3) merr = 1'b1;
      else mcnt[ISSUE_A3_D]++;
    end
    if (dec) begin
      if (mcnt[A3_W] == 0) merr = 1'b1;
      else mcnt[A3_W]--;
    end
  endfunction

  task automatic step(input bit rst, input bit we, input logic [4:0] a3,
                      input logic [31:0] res, input logic [4:0] a1, input logic [4:0] a2,
                      input bit iss, input bit iwe, input logic [4:0] ia3, input string tag);
    exp_t e;
    @(negedge clk);
    reset = rst; WE_W = we; A3_W = a3; RESULT_W = res; A1_D = a1; A2_D = a2;
    ISSUE_D = iss; ISSUE_WE_D = iwe; ISSUE_A3_D = ia3;
    e.rd1 = model_rd(a1);
    e.rd2 = model_rd(a2);
    e.b1  = model_busy(a1);
    e.b2  = model_busy(a2);
    e.err = reset ? 1'b0 : merr;
    e.tag = tag;
    exp_q.push_back(e);
    @(posedge clk);
    model_edge();
  endtask

  task automatic idle(input logic [4:0] a1, input logic [4:0] a2, input string tag);
    step(1'b0, 1'b0, 5'd0, 32'd0, a1, a2, 1'b0, 1'b0, 5'd0, tag);
  endtask

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] want);
    compared++;
    if (act !== want) begin
      mismatched++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endfunction

  // Monitor: outputs are combinational, so each cycle's response is sampled
  // mid-cycle, well clear of the rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk({e.tag, ".rd1"},  RD1_D, e.rd1);
        chk({e.tag, ".rd2"},  RD2_D, e.rd2);
        chk({e.tag, ".busy1"}, {31'd0, BUSY1_D}, {31'd0, e.b1});
        chk({e.tag, ".busy2"}, {31'd0, BUSY2_D}, {31'd0, e.b2});
        chk({e.tag, ".err"},  {31'd0, ERR}, {31'd0, e.err});
      end
    end
  end

  initial begin
    reset = 1'b1; WE_W = 1'b0; A3_W = 5'd0; RESULT_W = 32'd0; A1_D = 5'd0; A2_D = 5'd0;
    ISSUE_D = 1'b0; ISSUE_WE_D = 1'b0; ISSUE_A3_D = 5'd0;
    for (int i = 0; i < 32; i++) begin mregs[i] = 0; mcnt[i] = 0; end
    merr = 1'b0;

    // Reset, then every address on both ports reads zero and idle.
    step(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, "reset");
    for (int i = 0; i < 32; i++) idle(5'(i), 5'(31 - i), "rst_read");
    // Writes to r0 are dropped, also on the bypass path.
    step(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, "r0_write");
    idle(5'd0, 5'd0, "r0_read");

    // Same-cycle bypass, then the stored value.
    step(1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd0, 1'b0, 1'b0, 5'd0, "bypass");
    idle(5'd5, 5'd5, "stored");

    // Single in-flight write on r8, retired with bypass.
    step(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, "reset2");
    step(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd8, 1'b1, 1'b1, 5'd8, "issue_r8");
    idle(5'd0, 5'd8, "busy_r8");
    step(1'b0, 1'b1, 5'd8, 32'h12, 5'd0, 5'd8, 1'b0, 1'b0, 5'd0, "retire_r8");
    idle(5'd0, 5'd8, "after_r8");

    // Fill r9 to the limit, overflow once, then drain.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 5'd0, 32'd0, 5'd9, 5'd0, 1'b1, 1'b1, 5'd9, "issue_r9");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 5'd9, 32'(100 + i), 5'd9, 5'd9, 1'b0, 1'b0, 5'd0, "drain_r9");
    idle(5'd9, 5'd9, "empty_r9");

    // Issue and retire on one register in one cycle; then an underflow on r11.
    step(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, "reset3");
    step(1'b0, 1'b0, 5'd0, 32'd0, 5'd10, 5'd0, 1'b1, 1'b1, 5'd10, "issue_r10");
    step(1'b0, 1'b1, 5'd10, 32'hA5A5, 5'd10, 5'd0, 1'b1, 1'b1, 5'd10, "swap_r10");
    idle(5'd10, 5'd0, "held_r10");
    step(1'b0, 1'b1, 5'd11, 32'h1111, 5'd0, 5'd11, 1'b0, 1'b0, 5'd0, "underflow_r11");
    idle(5'd0, 5'd11, "after_r11");

    // Load r3 with two writes in flight and value 7, then reset over a write.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 5'd0, 32'd0, 5'd3, 5'd0, 1'b1, 1'b1, 5'd3, "issue_r3");
    step(1'b0, 1'b1, 5'd3, 32'd7, 5'd3, 5'd0, 1'b0, 1'b0, 5'd0, "write_r3");
    idle(5'd3, 5'd3, "loaded_r3");
    step(1'b1, 1'b1, 5'd3, 32'd99, 5'd3, 5'd4, 1'b1, 1'b1, 5'd3, "reset_wr");
    idle(5'd3, 5'd3, "post_reset");

    // Random traffic concentrated on a few registers so hazards are common.
    for (int n = 0; n < 3000; n++) begin
      logic [4:0] a3, a1, a2, ia3;
      a3  = ($urandom_range(0, 9) == 0) ? 5'($urandom) : 5'($urandom_range(0, 6));
      a1  = ($urandom_range(0, 9) == 0) ? 5'($urandom) : 5'($urandom_range(0, 6));
      a2  = ($urandom_range(0, 9) == 0) ? 5'($urandom) : 5'($urandom_range(0, 6));
      ia3 = 5'($urandom_range(0, 6));
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 4), a3, $urandom,
           a1, a2, ($urandom_range(0, 9) < 5), ($urandom_range(0, 9) < 8), ia3, "rand");
    end
    idle(5'd0, 5'd0, "tail");

    // Let the monitor drain; a stuck queue counts as a failure.
    for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(negedge clk);
    #5;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/grf_scoreboard.md
Name: grf_scoreboard

Overview:
- 32x32 general register file (GRF) that consumes the writeback result stream (write address, write enable, 32-bit result) and serves the decode stage's two read ports.
- Write-through bypass: a same-cycle writeback is visible to decode reads.
- Per-register in-flight scoreboard tracks destinations issued from decode but not yet written back; decode uses it to stall on true hazards.
- Sits between the W stage (producer) and the D stage (consumer).

Parameters:
- MAX_INFLIGHT, 3, maximum outstanding writes per register (E, M and W stages); counter width is 2 bits.
- REG_COUNT, 32, number of architectural registers; register 0 is hardwired to zero.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high; clears registers, counters and ERR on the next rising edge.
- WE_W  input  1  writeback write enable.
- A3_W  input  5  writeback destination register.
- RESULT_W  input  32  writeback data.
- A1_D  input  5  decode read address, port 1.
- A2_D  input  5  decode read address, port 2.
- RD1_D  output  32  read data, port 1 (combinational, bypassed).
- RD2_D  output  32  read data, port 2 (combinational, bypassed).
- ISSUE_D  input  1  an instruction leaves decode this cycle (not stalled, not a bubble).
- ISSUE_WE_D  input  1  the issuing instruction writes a register.
- ISSUE_A3_D  input  5  destination of the issuing instruction.
- BUSY1_D  output  1  A1_D has an outstanding write not satisfiable by bypass.
- BUSY2_D  output  1  same, for A2_D.
- ERR  output  1  sticky scoreboard error flag.

Behaviour:
Register file:
- Write: on a rising edge with WE_W=1 and A3_W!=0, reg[A3_W] <= RESULT_W.
- Writes to register 0 are ignored.
- Reset clears all 32 registers to 0.

Read ports:
- RDn_D = 0 if An_D==0.
- RDn_D = RESULT_W if WE_W=1 and A3_W==An_D (bypass).
- Otherwise RDn_D = reg[An_D].
- Purely combinational; zero latency.

Scoreboard:
- cnt[r], 2 bits per register, reset to 0; cnt[0] is held at 0.
- inc = ISSUE_D & ISSUE_WE_D & (ISSUE_A3_D!=0). Increments cnt[ISSUE_A3_D].
- dec = WE_W & (A3_W!=0). Decrements cnt[A3_W].
- inc and dec on the same register in the same cycle leave cnt unchanged.
- inc and dec on different registers both apply.
- Overflow: inc while cnt==MAX_INFLIGHT. Count holds and ERR <= 1.
- Underflow: dec while cnt==0. Count holds at 0, the write still commits, and ERR <= 1.
- ERR is cleared only by reset.

Busy outputs:
- BUSYn_D = (An_D!=0) & (cnt[An_D] - (dec & A3_W==An_D) != 0).
- A register whose only outstanding write is being written back this cycle is not busy, because the bypass supplies the data.
- BUSYn_D does not depend on ISSUE_* in the same cycle, so there is no combinational loop with the stall logic.

Reset:
- All outputs are 0 during and after reset (RDn_D=0, BUSYn_D=0, ERR=0), except RDn_D still bypasses RESULT_W when WE_W=1.
- Reset mid-operation discards every in-flight count; the pipeline is flushed by the same reset.
- Reset takes priority over simultaneous write, issue and retire.

Timing:
- A write committed at edge N is visible from reg[] after edge N and via bypass during the cycle before edge N.
- A count change at edge N is reflected in BUSY after edge N.

Test Plan:
- Reset, then read all 32 addresses on both ports -> RD1_D=RD2_D=0, BUSY=0, ERR=0. Write reg 0 with 32'hFFFFFFFF, then read A1_D=0 -> RD1_D=0.
- WE_W=1, A3_W=5, RESULT_W=32'hDEADBEEF with A1_D=5 in the same cycle -> RD1_D=32'hDEADBEEF before the edge (bypass). After the edge, with WE_W=0 -> RD1_D still 32'hDEADBEEF.
- Issue to r8 (cnt=1) and read A2_D=8 next cycle -> BUSY2_D=1. Then WE_W=1, A3_W=8, RESULT_W=32'h12 -> BUSY2_D=0 and RD2_D=32'h12 in that cycle; cnt=0 after the edge.
- Issue to r9 on three consecutive cycles -> cnt=3, ERR=0. A fourth issue -> ERR=1 after the edge, cnt stays 3. Then three writebacks to r9 -> BUSY drops only in the cycle of the third writeback.
- Issue to r10 and write back r10 in the same cycle, with prior cnt=1 -> cnt stays 1, BUSY1_D (A1_D=10) is 0 that cycle and 1 the next. Write back r11 with cnt=0 -> the register updates and ERR=1.
- Load cnt[3]=2 and reg[3]=7, then assert reset together with WE_W=1 to r3 -> after the edge cnt[3]=0, reg[3]=0, ERR=0, BUSY=0.
